// File: rtl/keypad_scanner_if.sv
`timescale 1ns/1ps
// keypad_scanner_if
// Pmod KYPD matrix keypad bundle plus the decoded key event outputs.
//   row       : keypad rows, active-low (keypad -> scanner)
//   col       : column strobe, active-low, one-hot-low (scanner -> keypad)
//   key_code  : hex code of last accepted key
//   key_valid : one-cycle press event
//   key_down  : key currently held (press accepted, release not yet accepted)
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   modport master (input row, output col, output key_code, output key_valid, output key_down);
   modport slave  (output row, input col, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
// Strobes the four keypad columns one at a time (active-low), samples the
// synchronized rows at the end of each column slot, classifies each full
// 4-column scan as NONE / SINGLE / MULTI and debounces on scan results.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   kp         : keypad_scanner_if.master (row in; col, key_code, key_valid,
//                key_down out)
// Parameters:
//   SCAN_DIV       : clock cycles per column slot (>= 2)
//   DEBOUNCE_SCANS : identical consecutive scans to accept press/release (>= 1)
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_scanner_if.master   kp
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   // Row index r*4+c -> hex legend printed on the keypad.
   function automatic logic [3:0] key_map(input logic [3:0] idx);
      case (idx)
         4'd0:  key_map = 4'h1;
         4'd1:  key_map = 4'h2;
         4'd2:  key_map = 4'h3;
         4'd3:  key_map = 4'hA;
         4'd4:  key_map = 4'h4;
         4'd5:  key_map = 4'h5;
         4'd6:  key_map = 4'h6;
         4'd7:  key_map = 4'hB;
         4'd8:  key_map = 4'h7;
         4'd9:  key_map = 4'h8;
         4'd10: key_map = 4'h9;
         4'd11: key_map = 4'hC;
         4'd12: key_map = 4'h0;
         4'd13: key_map = 4'hF;
         4'd14: key_map = 4'hE;
         default: key_map = 4'hD;
      endcase
   endfunction

   logic [3:0]    row_meta, row_sync;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic          slot_last, scan_end;
   logic [15:0]   snap, col_hits, snap_full;
   logic          any_key, single_key;
   logic [3:0]    hit_idx, hit_code;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic [3:0]    cand, cand_nx;
   logic [3:0]    code_q, code_nx;
   logic          valid_q, valid_nx;
   logic          down_q, down_nx;

   // Rows are asynchronous to clk; idle (pulled-up) value is all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= kp.row;
         row_sync <= row_meta;
      end
   end

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign scan_end  = slot_last && (col_idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         col_idx  <= 2'd0;
      end else if (slot_last) begin
         slot_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   assign kp.col = ~(4'b0001 << col_idx);

   // Hits of the column currently strobed, placed at bit r*4+c.
   always_comb begin
      col_hits = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            col_hits[r*4+c] = (col_idx == 2'(c)) && !row_sync[r];
   end

   // snap_full folds in the current slot's sample so that at scan end the
   // column-3 sample taken on that same cycle is part of the classification.
   assign snap_full = snap | col_hits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         snap <= '0;
      else if (scan_end)  snap <= '0;
      else if (slot_last) snap <= snap_full;
   end

   assign any_key    = |snap_full;
   assign single_key = any_key && ((snap_full & (snap_full - 16'd1)) == 16'd0);

   always_comb begin
      hit_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (snap_full[i]) hit_idx = 4'(i);
   end
   assign hit_code = key_map(hit_idx);
   assign cnt_inc  = cnt + CNT_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         cand    <= 4'd0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         down_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         cand    <= cand_nx;
         code_q  <= code_nx;
         valid_q <= valid_nx;
         down_q  <= down_nx;
      end
   end

   // Debounce FSM; advances only on scan-end results. MULTI never yields an
   // event, and once HELD further keys are ignored until a clean release.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      code_nx  = code_q;
      valid_nx = 1'b0;
      down_nx  = down_q;
      if (scan_end) begin
         case (state)
            IDLE: begin
               if (single_key) begin
                  cand_nx = hit_code;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nx = HELD;
                     cnt_nx   = '0;
                     code_nx  = hit_code;
                     valid_nx = 1'b1;
                     down_nx  = 1'b1;
                  end else begin
                     state_nx = PRESS_WAIT;
                     cnt_nx   = CNT_ONE;
                  end
               end
            end
            PRESS_WAIT: begin
               if (single_key && hit_code == cand) begin
                  if (cnt_inc == CNT_MAX) begin
                     state_nx = HELD;
                     cnt_nx   = '0;
                     code_nx  = cand;
                     valid_nx = 1'b1;
                     down_nx  = 1'b1;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            end
            HELD: begin
               if (!any_key) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                     down_nx  = 1'b0;
                  end else begin
                     state_nx = RELEASE_WAIT;
                     cnt_nx   = CNT_ONE;
                  end
               end
            end
            default: begin // RELEASE_WAIT
               if (!any_key) begin
                  if (cnt_inc == CNT_MAX) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                     down_nx  = 1'b0;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  state_nx = HELD;
                  cnt_nx   = '0;
               end
            end
         endcase
      end
   end

   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_down  = down_q;
endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scans).
// A keypad model pulls row r low while col c is low for each held key.
// Expected key events (code + arrival cycle) go to a scoreboard queue when a
// press is driven; the monitor pops and checks on every key_valid cycle.
module tb_keypad_scanner;
   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] keys;   // bit r*4+c = key at row r, col c held
   int          cyc;    // clock edges since reset release
   int          total;
   int          bad;
   exp_t        sb[$];

   keypad_scanner_if bus ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (bus.master)
   );

   assign bus.row[0] = ~|(keys[3:0]   & ~bus.col);
   assign bus.row[1] = ~|(keys[7:4]   & ~bus.col);
   assign bus.row[2] = ~|(keys[11:8]  & ~bus.col);
   assign bus.row[3] = ~|(keys[15:12] & ~bus.col);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Scoreboard monitor: every key_valid cycle must match the next expected event.
   always @(negedge clk) begin
      if (rst_n && bus.key_valid) begin
         exp_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: code=%0h at cyc=%0d, none expected", bus.key_code, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.key_code !== e.code || cyc !== e.cyc || bus.key_down !== 1'b1) begin
               bad++;
               $display("FAIL pulse: code=%0h cyc=%0d down=%b, want code=%0h cyc=%0d down=1",
                        bus.key_code, cyc, bus.key_down, e.code, e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic goto_scan_start();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (cyc % 16 == 0) break;
      end
   endtask

   task automatic check_sb_empty(input string name);
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL %s: %0d expected pulses missing, want 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      rst_n = 1'b0;
      keys  = 16'h0;
      repeat (2) @(negedge clk);
      total += 4;
      if (bus.col !== 4'b1110)    begin bad++; $display("FAIL rst_col: got %b want 1110", bus.col); end
      if (bus.key_code !== 4'h0)  begin bad++; $display("FAIL rst_code: got %h want 0", bus.key_code); end
      if (bus.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.key_valid); end
      if (bus.key_down !== 1'b0)  begin bad++; $display("FAIL rst_down: got %b want 0", bus.key_down); end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         exp_col = ~(4'b0001 << ((i / 4) % 4));
         total++;
         if (bus.col !== exp_col) begin
            bad++;
            $display("FAIL col_seq: cyc=%0d got %b want %b", i, bus.col, exp_col);
         end
         @(negedge clk);
      end
      repeat (16 * 50 - 20) @(negedge clk);
      total += 2;
      if (bus.key_down !== 1'b0) begin bad++; $display("FAIL idle_down: got %b want 0", bus.key_down); end
      if (bus.key_code !== 4'h0) begin bad++; $display("FAIL idle_code: got %h want 0", bus.key_code); end
   endtask

   task automatic test_bounce();
      goto_scan_start();
      keys = 16'h0100;              // '7' row2/col0
      repeat (16) @(negedge clk);
      keys = 16'h0;
      repeat (16) @(negedge clk);
      keys = 16'h0100;
      repeat (32) @(negedge clk);
      keys = 16'h0;
      repeat (16 * 4) @(negedge clk);
      total += 2;
      if (bus.key_code !== 4'h0) begin bad++; $display("FAIL bounce_code: got %h want 0", bus.key_code); end
      if (bus.key_down !== 1'b0) begin bad++; $display("FAIL bounce_down: got %b want 0", bus.key_down); end
      check_sb_empty("bounce_sb");
   endtask

   task automatic test_hold_5();
      int acc;
      goto_scan_start();
      keys = 16'h0020;              // '5' row1/col1
      acc  = cyc + 48;
      sb.push_back('{code: 4'h5, cyc: acc});
      for (int i = 0; i < 16 * 20; i++) begin
         total++;
         if (bus.key_down !== (cyc >= acc)) begin
            bad++;
            $display("FAIL hold5_down: cyc=%0d got %b want %b", cyc, bus.key_down, cyc >= acc);
         end
         @(negedge clk);
      end
      total++;
      if (bus.key_code !== 4'h5) begin bad++; $display("FAIL hold5_code: got %h want 5", bus.key_code); end
      check_sb_empty("hold5_sb");
   endtask

   task automatic test_release_then_d();
      goto_scan_start();
      keys = 16'h0;
      repeat (47) @(negedge clk);
      total++;
      if (bus.key_down !== 1'b1) begin bad++; $display("FAIL rel_down_early: got %b want 1", bus.key_down); end
      @(negedge clk);
      total++;
      if (bus.key_down !== 1'b0) begin bad++; $display("FAIL rel_down_fall: got %b want 0", bus.key_down); end
      goto_scan_start();
      keys = 16'h8000;              // 'D' row3/col3
      sb.push_back('{code: 4'hD, cyc: cyc + 48});
      repeat (16 * 4) @(negedge clk);
      total += 2;
      if (bus.key_code !== 4'hD) begin bad++; $display("FAIL d_code: got %h want d", bus.key_code); end
      if (bus.key_down !== 1'b1) begin bad++; $display("FAIL d_down: got %b want 1", bus.key_down); end
      check_sb_empty("d_sb");
      keys = 16'h0;
      repeat (16 * 5) @(negedge clk);
      total++;
      if (bus.key_down !== 1'b0) begin bad++; $display("FAIL d_release: got %b want 0", bus.key_down); end
   endtask

   task automatic test_multi();
      goto_scan_start();
      keys = 16'h0003;              // '1' and '2' together
      repeat (16 * 5) @(negedge clk);
      check_sb_empty("multi_sb");
      goto_scan_start();
      keys = 16'h0001;              // '1' alone
      sb.push_back('{code: 4'h1, cyc: cyc + 48});
      repeat (16 * 3 + 1) @(negedge clk);
      goto_scan_start();
      keys = 16'h0003;              // roll over onto '2'
      repeat (16 * 5) @(negedge clk);
      total += 2;
      if (bus.key_code !== 4'h1) begin bad++; $display("FAIL rollover_code: got %h want 1", bus.key_code); end
      if (bus.key_down !== 1'b1) begin bad++; $display("FAIL rollover_down: got %b want 1", bus.key_down); end
      check_sb_empty("rollover_sb");
      keys = 16'h0;
      repeat (16 * 5) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      goto_scan_start();
      keys = 16'h0008;              // 'A' row0/col3
      sb.push_back('{code: 4'hA, cyc: cyc + 48});
      repeat (16 * 3 + 6) @(negedge clk);
      total++;
      if (bus.key_code !== 4'hA) begin bad++; $display("FAIL a_code: got %h want a", bus.key_code); end
      check_sb_empty("a_sb");
      rst_n = 1'b0;
      #1;
      total += 3;
      if (bus.key_down !== 1'b0) begin bad++; $display("FAIL midrst_down: got %b want 0", bus.key_down); end
      if (bus.key_code !== 4'h0) begin bad++; $display("FAIL midrst_code: got %h want 0", bus.key_code); end
      if (bus.col !== 4'b1110)   begin bad++; $display("FAIL midrst_col: got %b want 1110", bus.col); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{code: 4'hA, cyc: 48});
      repeat (16 * 4) @(negedge clk);
      total++;
      if (bus.key_code !== 4'hA) begin bad++; $display("FAIL a_again_code: got %h want a", bus.key_code); end
      check_sb_empty("a_again_sb");
      keys = 16'h0;
      repeat (16 * 5) @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      keys  = 16'h0;
      test_reset();
      test_bounce();
      test_hold_5();
      test_release_then_d();
      test_multi();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
